// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: two L1 ports share one L2 request channel under round-robin arbitration.
// A granted request is latched, issued to L2, then acknowledged back to its owning port.
module l1_l2_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               p_rd_req,
    input  logic [1:0]               p_wr_req,
    input  logic [1:0]               p_wb_req,
    input  logic [ADDRESS_WIDTH-1:0] p_addr    [2],
    input  logic [DATA_WIDTH-1:0]    p_wr_data [2],
    input  logic [LINE_WIDTH-1:0]    p_wb_data [2],
    output logic [1:0]               p_rd_done,
    output logic [1:0]               p_wr_done,
    output logic [1:0]               p_wb_done,
    output logic [LINE_WIDTH-1:0]    p_rd_data,
    output logic                     l2_rd_req,
    output logic                     l2_wr_req,
    output logic                     l2_wb_req,
    output logic [ADDRESS_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0]    l2_wr_data,
    output logic [LINE_WIDTH-1:0]    l2_wb_data,
    input  logic                     l2_rd_done,
    input  logic                     l2_wr_done,
    input  logic                     l2_wb_done,
    input  logic [LINE_WIDTH-1:0]    l2_rd_data,
    output logic [CNT_WIDTH-1:0]     svc_cnt   [2]
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
    typedef enum logic [1:0] {T_RD, T_WR, T_WB} type_t;

    state_t                   r_state, w_state_next;
    type_t                    r_type, w_gnt_type;
    logic                     r_owner, r_last_grant;
    logic [1:0]               w_req;
    logic                     w_gnt, w_l2_match;
    logic [1:0]               w_owner_mask;
    logic [ADDRESS_WIDTH-1:0] r_l2_addr;
    logic [DATA_WIDTH-1:0]    r_l2_wr_data;
    logic [LINE_WIDTH-1:0]    r_l2_wb_data, r_p_rd_data;
    logic                     r_l2_rd_req, r_l2_wr_req, r_l2_wb_req;
    logic [1:0]               r_p_rd_done, r_p_wr_done, r_p_wb_done;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [CNT_WIDTH-1:0] r_cnt;

        assign w_req[gi] = p_rd_req[gi] | p_wr_req[gi] | p_wb_req[gi];

        // Counter saturates instead of wrapping so a long-running port never reads as idle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_cnt <= '0;
            else if (r_state == RESPOND && r_owner == 1'(gi) && r_cnt != '1)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end

        assign svc_cnt[gi] = r_cnt;
    end

    always_comb begin
        w_gnt = ~r_last_grant;
        if (w_req == 2'b01)
            w_gnt = 1'b0;
        else if (w_req == 2'b10)
            w_gnt = 1'b1;

        if (p_wb_req[w_gnt])
            w_gnt_type = T_WB;
        else if (p_wr_req[w_gnt])
            w_gnt_type = T_WR;
        else
            w_gnt_type = T_RD;

        unique case (r_type)
            T_RD:    w_l2_match = l2_rd_done;
            T_WR:    w_l2_match = l2_wr_done;
            T_WB:    w_l2_match = l2_wb_done;
            default: w_l2_match = 1'b0;
        endcase

        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (|w_req) w_state_next = ISSUE;
            ISSUE:   if (w_l2_match) w_state_next = RESPOND;
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_owner_mask = r_owner ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_type       <= T_RD;
            r_last_grant <= 1'b1;
            r_l2_addr    <= '0;
            r_l2_wr_data <= '0;
            r_l2_wb_data <= '0;
            r_p_rd_data  <= '0;
            r_l2_rd_req  <= 1'b0;
            r_l2_wr_req  <= 1'b0;
            r_l2_wb_req  <= 1'b0;
            r_p_rd_done  <= 2'b00;
            r_p_wr_done  <= 2'b00;
            r_p_wb_done  <= 2'b00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner      <= w_gnt;
                        r_type       <= w_gnt_type;
                        r_l2_addr    <= p_addr[w_gnt];
                        r_l2_wr_data <= p_wr_data[w_gnt];
                        r_l2_wb_data <= p_wb_data[w_gnt];
                        r_l2_rd_req  <= (w_gnt_type == T_RD);
                        r_l2_wr_req  <= (w_gnt_type == T_WR);
                        r_l2_wb_req  <= (w_gnt_type == T_WB);
                    end
                end
                ISSUE: begin
                    if (w_l2_match) begin
                        r_l2_rd_req <= 1'b0;
                        r_l2_wr_req <= 1'b0;
                        r_l2_wb_req <= 1'b0;
                        if (r_type == T_RD)
                            r_p_rd_data <= l2_rd_data;
                        r_p_rd_done <= (r_type == T_RD) ? w_owner_mask : 2'b00;
                        r_p_wr_done <= (r_type == T_WR) ? w_owner_mask : 2'b00;
                        r_p_wb_done <= (r_type == T_WB) ? w_owner_mask : 2'b00;
                    end
                end
                RESPOND: begin
                    r_p_rd_done  <= 2'b00;
                    r_p_wr_done  <= 2'b00;
                    r_p_wb_done  <= 2'b00;
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign p_rd_done  = r_p_rd_done;
    assign p_wr_done  = r_p_wr_done;
    assign p_wb_done  = r_p_wb_done;
    assign p_rd_data  = r_p_rd_data;
    assign l2_rd_req  = r_l2_rd_req;
    assign l2_wr_req  = r_l2_wr_req;
    assign l2_wb_req  = r_l2_wb_req;
    assign l2_addr    = r_l2_addr;
    assign l2_wr_data = r_l2_wr_data;
    assign l2_wb_data = r_l2_wb_data;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: scoreboard bench; expected port completions are queued as requests are
// raised and popped as done pulses appear, with an L2 model answering after a fixed latency.
module tb_l1_l2_arbiter;

    localparam int T_RD = 0;
    localparam int T_WR = 1;
    localparam int T_WB = 2;
    localparam int LAT  = 3;

    typedef struct {
        int           port;
        int           typ;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   p_rd_req, p_wr_req, p_wb_req;
    logic [31:0]  p_addr    [2];
    logic [31:0]  p_wr_data [2];
    logic [127:0] p_wb_data [2];
    logic [1:0]   p_rd_done, p_wr_done, p_wb_done;
    logic [127:0] p_rd_data;
    logic         l2_rd_req, l2_wr_req, l2_wb_req;
    logic [31:0]  l2_addr;
    logic [31:0]  l2_wr_data;
    logic [127:0] l2_wb_data;
    logic         l2_rd_done, l2_wr_done, l2_wb_done;
    logic [127:0] l2_rd_data;
    logic [3:0]   svc_cnt   [2];

    logic auto_l2;
    logic ar, aw, ab;
    logic man_rd, man_wr, man_wb;
    int   lat;
    exp_t sb[$];
    int   cnt_m [2];
    int   n_total = 0;
    int   n_bad   = 0;

    assign l2_rd_done = ar | man_rd;
    assign l2_wr_done = aw | man_wr;
    assign l2_wb_done = ab | man_wb;

    always #5 clk = ~clk;

    l1_l2_arbiter #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LINE_WIDTH(128), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .p_rd_req(p_rd_req), .p_wr_req(p_wr_req), .p_wb_req(p_wb_req),
        .p_addr(p_addr), .p_wr_data(p_wr_data), .p_wb_data(p_wb_data),
        .p_rd_done(p_rd_done), .p_wr_done(p_wr_done), .p_wb_done(p_wb_done),
        .p_rd_data(p_rd_data),
        .l2_rd_req(l2_rd_req), .l2_wr_req(l2_wr_req), .l2_wb_req(l2_wb_req),
        .l2_addr(l2_addr), .l2_wr_data(l2_wr_data), .l2_wb_data(l2_wb_data),
        .l2_rd_done(l2_rd_done), .l2_wr_done(l2_wr_done), .l2_wb_done(l2_wb_done),
        .l2_rd_data(l2_rd_data),
        .svc_cnt(svc_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // L2 model: answers the pending request LAT cycles after it appears.
    initial begin
        ar = 1'b0; aw = 1'b0; ab = 1'b0; lat = 0;
        forever begin
            @(posedge clk);
            #1;
            ar = 1'b0; aw = 1'b0; ab = 1'b0;
            if (auto_l2 && (l2_rd_req || l2_wr_req || l2_wb_req)) begin
                if (lat == LAT - 1) begin
                    ar = l2_rd_req; aw = l2_wr_req; ab = l2_wb_req;
                    lat = 0;
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Port-side monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic d;
        exp_t e;
        if (reset) begin
            cnt_m[0] = 0;
            cnt_m[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int t = 0; t < 3; t++) begin
                    d = (t == T_RD) ? p_rd_done[p] : (t == T_WR) ? p_wr_done[p] : p_wb_done[p];
                    if (d) begin
                        if (sb.size() == 0) begin
                            chk("unexp_done", 128'({p_wb_done, p_wr_done, p_rd_done}), 128'(0));
                        end else begin
                            e = sb.pop_front();
                            $display("txn port=%0d type=%0d rd_data=%0h", p, t, p_rd_data);
                            chk("done_id", 128'(p * 4 + t), 128'(e.port * 4 + e.typ));
                            if (t == T_RD)
                                chk("rd_data", p_rd_data, e.data);
                            if (cnt_m[p] != 15)
                                cnt_m[p] = cnt_m[p] + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int port, input int typ, input logic [127:0] data);
        exp_t e;
        e.port = port; e.typ = typ; e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_sb(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == target) break;
        end
        if (i == budget) chk("timeout_sb", 128'(sb.size()), 128'(target));
    endtask

    task automatic wait_l2(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (l2_rd_req || l2_wr_req || l2_wb_req) break;
        end
        if (i == budget) chk("timeout_l2", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(1));
    endtask

    initial begin
        logic [127:0] line;
        reset = 1'b0;
        auto_l2 = 1'b1;
        man_rd = 1'b0; man_wr = 1'b0; man_wb = 1'b0;
        p_rd_req = 2'b00; p_wr_req = 2'b00; p_wb_req = 2'b00;
        p_addr[0] = 32'h1000_0000; p_addr[1] = 32'h2000_0000;
        p_wr_data[0] = 32'h1111_1111; p_wr_data[1] = 32'h2222_2222;
        p_wb_data[0] = '0; p_wb_data[1] = '0;
        l2_rd_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ctl", 128'({l2_rd_req, l2_wr_req, l2_wb_req, p_rd_done, p_wr_done, p_wb_done}), 128'(0));
        chk("rst_addr", 128'(l2_addr), 128'(0));
        chk("rst_wbdata", l2_wb_data, 128'(0));
        chk("rst_rdata", p_rd_data, 128'(0));
        chk("rst_cnt", 128'({svc_cnt[0], svc_cnt[1]}), 128'(0));

        // Contention: both ports write continuously, grants alternate starting at port 0.
        p_wr_req = 2'b11;
        for (int i = 0; i < 4; i++) push(i % 2, T_WR, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_sb(0, 200);
        p_wr_req = 2'b00;
        tick(2);
        chk("cont_cnt0", 128'(svc_cnt[0]), 128'(2));
        chk("cont_cnt1", 128'(svc_cnt[1]), 128'(2));

        // Single read on port 1.
        p_addr[1] = 32'h4000_0040;
        line = {4{32'hDEADBEEF}};
        l2_rd_data = line;
        push(1, T_RD, line);
        p_rd_req = 2'b10;
        wait_l2(50);
        chk("rd_req", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(3'b100));
        chk("rd_addr", 128'(l2_addr), 128'(32'h4000_0040));
        wait_sb(0, 50);
        p_rd_req = 2'b00;
        tick(3);
        chk("rd_cnt1", 128'(svc_cnt[1]), 128'(cnt_m[1]));
        chk("rd_hold", p_rd_data, line);

        // Type priority: wb beats rd on the same port; rd follows once wb drops.
        p_addr[0] = 32'h3000_0100;
        p_wb_data[0] = {4{32'hA5A5_0F0F}};
        line = {32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978};
        l2_rd_data = line;
        push(0, T_WB, '0);
        push(0, T_RD, line);
        p_wb_req = 2'b01;
        p_rd_req = 2'b01;
        wait_l2(50);
        chk("prio_req", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(3'b001));
        chk("prio_wbdata", l2_wb_data, {4{32'hA5A5_0F0F}});
        p_wb_data[0] = '1;
        p_addr[0] = 32'hFFFF_FFFC;
        tick(1);
        chk("prio_wb_stable", l2_wb_data, {4{32'hA5A5_0F0F}});
        chk("prio_addr_stable", 128'(l2_addr), 128'(32'h3000_0100));
        wait_sb(1, 50);
        p_wb_req = 2'b00;
        wait_l2(50);
        chk("prio_rd_req", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(3'b100));
        chk("prio_rd_addr", 128'(l2_addr), 128'(32'hFFFF_FFFC));
        wait_sb(0, 50);
        p_rd_req = 2'b00;
        tick(2);

        // Stray completion: a wr done during a read must be ignored.
        auto_l2 = 1'b0;
        p_addr[0] = 32'h5000_0000;
        line = {4{32'hCAFE_F00D}};
        l2_rd_data = line;
        push(0, T_RD, line);
        p_rd_req = 2'b01;
        wait_l2(50);
        man_wr = 1'b1;
        tick(1);
        man_wr = 1'b0;
        tick(1);
        chk("stray_hold", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(3'b100));
        chk("stray_pending", 128'(sb.size()), 128'(1));
        man_rd = 1'b1;
        tick(1);
        man_rd = 1'b0;
        wait_sb(0, 10);
        p_rd_req = 2'b00;
        tick(2);

        // Reset during a write-back abandons it; the late L2 done is ignored.
        p_wb_data[1] = {4{32'h7777_8888}};
        p_addr[1] = 32'h6000_0000;
        p_wb_req = 2'b10;
        wait_l2(50);
        chk("rst_wb_req", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(3'b001));
        #1 reset = 1'b1;
        #1;
        chk("rstmid_ctl", 128'({l2_rd_req, l2_wr_req, l2_wb_req, p_rd_done, p_wr_done, p_wb_done}), 128'(0));
        chk("rstmid_addr", 128'(l2_addr), 128'(0));
        chk("rstmid_wbdata", l2_wb_data, 128'(0));
        chk("rstmid_rdata", p_rd_data, 128'(0));
        p_wb_req = 2'b00;
        tick(2);
        reset = 1'b0;
        man_wb = 1'b1;
        tick(1);
        man_wb = 1'b0;
        tick(3);
        chk("late_done_req", 128'({l2_rd_req, l2_wr_req, l2_wb_req}), 128'(0));
        chk("late_done_cnt", 128'({svc_cnt[0], svc_cnt[1]}), 128'(0));
        auto_l2 = 1'b1;

        // Saturation: 17 port-0 writes with a 4-bit counter.
        p_addr[0] = 32'h7000_0000;
        for (int i = 0; i < 17; i++) push(0, T_WR, '0);
        p_wr_req = 2'b01;
        wait_sb(0, 600);
        p_wr_req = 2'b00;
        tick(2);
        chk("sat_cnt", 128'(svc_cnt[0]), 128'(15));
        chk("sat_model", 128'(svc_cnt[0]), 128'(cnt_m[0]));
        chk("sat_cnt1", 128'(svc_cnt[1]), 128'(0));

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
